// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - uart_state_e   : receiver state encoding
//   - UART_DATA_BITS : payload bits per frame (8N1)
//   - UART_CLKS_PER_BIT : default bit period in clk cycles, shared with the transmitter
`timescale 1ns/1ps
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchroniser for a single asynchronous input.
//   clk   in  sampling clock
//   rst_n in  asynchronous active-low reset; every stage resets to 1
//   d     in  asynchronous input
//   q     out synchronised output (SYNC_STAGES cycles of latency)
// Resetting to 1 matches an idle-high serial line, so leaving reset never looks like an edge.
`timescale 1ns/1ps
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART frame receiver, LSB first, idle-high line.
//   clk       in   system clock, all logic on posedge
//   rst_n     in   asynchronous active-low reset
//   rx        in   serial line, asynchronous to clk
//   data      out  last correctly received byte
//   valid     out  one-cycle pulse, data updated this cycle
//   frame_err out  one-cycle pulse, stop bit sampled low
//   busy      out  high while a frame is in progress
// The start bit is re-checked at its middle to reject glitches; from there every bit is
// sampled one full bit period later, i.e. at its own middle.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    uart_state_e                state_q, state_d;
    logic [CNT_W-1:0]           clk_cnt_q, clk_cnt_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]  data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    // Line back high at mid start bit: treat as a glitch, no outputs.
                    state_d   = rx_s ? StIdle : StData;
                end
            end

            StData: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
                        state_d   = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            StStop: begin
                if (clk_cnt_q == CNT_FULL) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        // IDLE is re-entered at mid stop bit so a back-to-back start is caught.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end
            end

            StBreak: begin
                // Hold off until the line returns high so a held-low line cannot retrigger.
                clk_cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = StIdle;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int         cyc = 0;
    int         vcnt = 0;
    int         fcnt = 0;
    int         both_cnt = 0;
    int         vcyc = 0;
    logic [7:0] vdata [0:31];
    int         start_cyc = 0;

    // Per-edge jitter offsets (clocks) for edges 0..10 of a frame
    int jt [0:10] = '{0, 2, -2, 1, -1, 2, -2, 0, 1, -1, 0};

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vdata[vcnt % 32] <= data;
            vcnt             <= vcnt + 1;
            vcyc             <= cyc;
        end
        if (frame_err) fcnt <= fcnt + 1;
        if (valid && frame_err) both_cnt <= both_cnt + 1;
    end

    // Drives start, 8 data bits LSB first and stop, each for one bit period (jitter-scaled).
    task automatic send_frame(input logic [7:0] b, input logic stop, input int jsign);
        logic [9:0] bits;
        int         dur;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rx = bits[k];
            if (k == 0) start_cyc = cyc;
            dur = CPB + jsign * (jt[k+1] - jt[k]);
            repeat (dur - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h expected 00", data);
        end
        checks++;
        if (valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got valid=%b frame_err=%b expected 0 0", valid, frame_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || vcnt != 0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b vcnt=%0d expected 0 0", busy, vcnt);
        end
    endtask

    task automatic test_single;
        int v0, f0, lat;
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'hA5, 1'b1, 0);
        idle(4);
        checks++;
        if (vcnt != v0 + 1) begin
            errors++;
            $display("FAIL single_count: got %0d valid pulses expected 1", vcnt - v0);
        end
        checks++;
        if (data !== 8'hA5) begin
            errors++;
            $display("FAIL single_data: got %h expected a5", data);
        end
        checks++;
        if (fcnt != f0) begin
            errors++;
            $display("FAIL single_ferr: got %0d frame_err pulses expected 0", fcnt - f0);
        end
        lat = vcyc - start_cyc;
        checks++;
        if (lat < 154 || lat > 156) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles expected 155 +/-1", lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int v0, f0;
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        idle(4);
        checks++;
        if (vcnt != v0 + 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d valid pulses expected 2", vcnt - v0);
        end else begin
            checks++;
            if (vdata[v0 % 32] !== 8'h00) begin
                errors++;
                $display("FAIL b2b_first: got %h expected 00", vdata[v0 % 32]);
            end
            checks++;
            if (vdata[(v0 + 1) % 32] !== 8'hFF) begin
                errors++;
                $display("FAIL b2b_second: got %h expected ff", vdata[(v0 + 1) % 32]);
            end
        end
        checks++;
        if (fcnt != f0) begin
            errors++;
            $display("FAIL b2b_ferr: got %0d frame_err pulses expected 0", fcnt - f0);
        end
    endtask

    task automatic test_glitch;
        int v0, f0, bcyc;
        v0   = vcnt;
        f0   = fcnt;
        bcyc = 0;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy) bcyc++;
        end
        rx = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy) bcyc++;
        end
        checks++;
        if (bcyc < 1 || bcyc > SYNC + 8) begin
            errors++;
            $display("FAIL glitch_busy_len: got %0d cycles expected 1..%0d", bcyc, SYNC + 8);
        end
        checks++;
        if (vcnt != v0 || fcnt != f0) begin
            errors++;
            $display("FAIL glitch_strobes: got %0d valid %0d ferr expected 0 0",
                     vcnt - v0, fcnt - f0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'h3C, 1'b0, 0);
        repeat (40) @(negedge clk);
        checks++;
        if (fcnt != f0 + 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d frame_err pulses expected 1", fcnt - f0);
        end
        checks++;
        if (vcnt != v0) begin
            errors++;
            $display("FAIL ferr_valid: got %0d valid pulses expected 0", vcnt - v0);
        end
        checks++;
        if (data !== 8'hFF) begin
            errors++;
            $display("FAIL ferr_data_hold: got %h expected ff", data);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ferr_break_busy: got %b expected 1", busy);
        end
        idle(2 * CPB);
        checks++;
        if (busy !== 1'b0 || vcnt != v0) begin
            errors++;
            $display("FAIL ferr_recover: got busy=%b valid=%0d expected 0 0", busy, vcnt - v0);
        end
        send_frame(8'h81, 1'b1, 0);
        idle(4);
        checks++;
        if (vcnt != v0 + 1 || data !== 8'h81) begin
            errors++;
            $display("FAIL ferr_next_frame: got %0d valid data=%h expected 1 81",
                     vcnt - v0, data);
        end
    endtask

    task automatic test_reset_mid;
        int         v0, f0;
        logic [9:0] bits;
        idle(CPB);
        v0   = vcnt;
        f0   = fcnt;
        bits = {1'b1, 8'h55, 1'b0};
        // Start bit and data bits 0..2, then half of bit 3
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rx = bits[k];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = bits[4];
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy_before: got %b expected 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got data=%h valid=%b ferr=%b busy=%b expected 00 0 0 0",
                     data, valid, frame_err, busy);
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10 * CPB) @(negedge clk);
        checks++;
        if (vcnt != v0 || fcnt != f0) begin
            errors++;
            $display("FAIL rstmid_no_output: got %0d valid %0d ferr expected 0 0",
                     vcnt - v0, fcnt - f0);
        end
        send_frame(8'h81, 1'b1, 0);
        idle(4);
        checks++;
        if (vcnt != v0 + 1 || data !== 8'h81) begin
            errors++;
            $display("FAIL rstmid_next_frame: got %0d valid data=%h expected 1 81",
                     vcnt - v0, data);
        end
    endtask

    task automatic test_jitter;
        int v0, f0;
        idle(CPB);
        v0 = vcnt;
        f0 = fcnt;
        send_frame(8'h96, 1'b1, 1);
        idle(4);
        checks++;
        if (vcnt != v0 + 1 || data !== 8'h96) begin
            errors++;
            $display("FAIL jitter_96: got %0d valid data=%h expected 1 96", vcnt - v0, data);
        end
        send_frame(8'h69, 1'b1, -1);
        idle(4);
        checks++;
        if (vcnt != v0 + 2 || data !== 8'h69) begin
            errors++;
            $display("FAIL jitter_69: got %0d valid data=%h expected 2 69", vcnt - v0, data);
        end
        checks++;
        if (fcnt != f0) begin
            errors++;
            $display("FAIL jitter_ferr: got %0d frame_err pulses expected 0", fcnt - f0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_jitter();
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL valid_with_ferr: got %0d overlapping cycles expected 0", both_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a task never returns
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
